// File: rtl/routed_lock_bus_if.sv
// ---------------------------------------------------------------------------
// routed_lock_bus_if
//
// Purpose: groups the input-side and output-side handshake/data signals of
// routed_lock_bus so that the bus and its neighbours connect through one
// port.
//
// Optional feature macro: CORERISCV_BUS_DST_CHECK_EN (adds err_src).
//
// Signals:
//   in_valid   [N_IN]            per-input valid
//   in_ready   [N_IN]            per-input ready
//   in_src     [N_IN*SRC_W]      header_src, input i at [i*SRC_W +: SRC_W]
//   in_dst     [N_IN*DST_W]      header_dst, packed the same way
//   in_payload [N_IN*PAYLOAD_W]  payload, packed the same way
//   in_last    [N_IN]            final beat of a message
//   out_valid  [N_OUT]           per-output valid
//   out_ready  [N_OUT]           per-output ready
//   out_src/out_dst/out_payload/out_last   shared registered beat fields
//   chosen     [IDX_W]           input index of the held beat
//   err                          sticky out-of-range flag
//   err_src    [SRC_W]           first offending src (feature only)
//
// Modports: master = traffic source/sink around the bus, slave = the bus.
// ---------------------------------------------------------------------------
interface routed_lock_bus_if #(
    parameter int N_IN      = 4,
    parameter int N_OUT     = 4,
    parameter int SRC_W     = 2,
    parameter int DST_W     = 2,
    parameter int PAYLOAD_W = 2,
    parameter int IDX_W     = 2
);
    logic [N_IN-1:0]           in_valid;
    logic [N_IN-1:0]           in_ready;
    logic [N_IN*SRC_W-1:0]     in_src;
    logic [N_IN*DST_W-1:0]     in_dst;
    logic [N_IN*PAYLOAD_W-1:0] in_payload;
    logic [N_IN-1:0]           in_last;
    logic [N_OUT-1:0]          out_valid;
    logic [N_OUT-1:0]          out_ready;
    logic [SRC_W-1:0]          out_src;
    logic [DST_W-1:0]          out_dst;
    logic [PAYLOAD_W-1:0]      out_payload;
    logic                      out_last;
    logic [IDX_W-1:0]          chosen;
    logic                      err;
`ifdef CORERISCV_BUS_DST_CHECK_EN
    logic [SRC_W-1:0]          err_src;
`endif

    modport master (
        output in_valid, in_src, in_dst, in_payload, in_last, out_ready,
        input  in_ready, out_valid, out_src, out_dst, out_payload, out_last,
        input  chosen, err
`ifdef CORERISCV_BUS_DST_CHECK_EN
        , input err_src
`endif
    );

    modport slave (
        input  in_valid, in_src, in_dst, in_payload, in_last, out_ready,
        output in_ready, out_valid, out_src, out_dst, out_payload, out_last,
        output chosen, err
`ifdef CORERISCV_BUS_DST_CHECK_EN
        , output err_src
`endif
    );
endinterface

// File: rtl/routed_lock_bus.sv
// ---------------------------------------------------------------------------
// routed_lock_bus
//
// Purpose: N_IN-to-N_OUT routed bus. A locking round-robin arbiter picks one
// input stream; the winning beat is captured in a one-entry output register
// and offered to the output selected by its header_dst. Multi-beat messages
// keep the grant until their last beat is accepted. Beats whose destination
// is >= N_OUT are consumed but never presented.
//
// Optional feature macro: CORERISCV_BUS_DST_CHECK_EN
//   defined   -> sticky err flag plus err_src capture of the first bad src
//   undefined -> bad beats silently dropped, err tied low
//
// Ports:
//   clk    clock
//   reset  synchronous reset, active-low
//   bus    routed_lock_bus_if.slave (all handshake and data signals)
// ---------------------------------------------------------------------------
module routed_lock_bus #(
    parameter int N_IN      = 4,
    parameter int N_OUT     = 4,
    parameter int SRC_W     = 2,
    parameter int DST_W     = 2,
    parameter int PAYLOAD_W = 2,
    parameter int IDX_W     = 2
) (
    input logic              clk,
    input logic              reset,
    routed_lock_bus_if.slave bus
);

    typedef enum logic {
        LOCK_OPEN,
        LOCK_HELD
    } lockState_t;

    lockState_t           lockState_q, lockState_d;
    logic [IDX_W-1:0]     lockIdx_q, lockIdx_d;
    logic [IDX_W-1:0]     rrPtr_q, rrPtr_d;
    logic [IDX_W-1:0]     chosen_q, chosen_d;
    logic                 regValid_q, regValid_d;
    logic [SRC_W-1:0]     regSrc_q, regSrc_d;
    logic [DST_W-1:0]     regDst_q, regDst_d;
    logic [PAYLOAD_W-1:0] regPayload_q, regPayload_d;
    logic                 regLast_q, regLast_d;

    logic                 drain;
    logic                 pipeReady;
    logic [IDX_W-1:0]     grant;
    logic                 grantValid;
    int                   bestDist;
    int                   candDist;
    logic                 accept;
    logic                 inRange;
    logic [SRC_W-1:0]     selSrc;
    logic [DST_W-1:0]     selDst;
    logic [PAYLOAD_W-1:0] selPayload;
    logic                 selLast;

    // The held beat leaves when the output it targets is ready; a free or
    // draining register can take a new beat in the same cycle.
    always_comb begin
        drain = 1'b0;
        for (int j = 0; j < N_OUT; j++) begin
            if (int'(regDst_q) == j) begin
                drain = regValid_q & bus.out_ready[j];
            end
        end
        pipeReady = ~regValid_q | drain;
    end

    // Grant selection. While a message is open the grant is pinned to its
    // owner. Otherwise the winner is the valid input nearest after rrPtr_q,
    // measured as a modular distance so the search wraps without an
    // explicit rotation.
    always_comb begin
        grant      = rrPtr_q;
        grantValid = 1'b0;
        bestDist   = N_IN;
        candDist   = 0;
        if (lockState_q == LOCK_HELD) begin
            grant = lockIdx_q;
            for (int i = 0; i < N_IN; i++) begin
                if (int'(lockIdx_q) == i) begin
                    grantValid = bus.in_valid[i];
                end
            end
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                candDist = (i + 2 * N_IN - int'(rrPtr_q) - 1) % N_IN;
                if (bus.in_valid[i] && (candDist < bestDist)) begin
                    bestDist   = candDist;
                    grant      = IDX_W'(i);
                    grantValid = 1'b1;
                end
            end
        end
    end

    // Ready depends only on valids, the grant and the output side, never on
    // the header or payload of the inputs.
    always_comb begin
        bus.in_ready = '0;
        for (int i = 0; i < N_IN; i++) begin
            bus.in_ready[i] = pipeReady & grantValid & (int'(grant) == i);
        end
        accept = pipeReady & grantValid;
    end

    // Mux the granted input's header and payload for loading.
    always_comb begin
        selSrc     = '0;
        selDst     = '0;
        selPayload = '0;
        selLast    = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            if (int'(grant) == i) begin
                selSrc     = bus.in_src[i*SRC_W +: SRC_W];
                selDst     = bus.in_dst[i*DST_W +: DST_W];
                selPayload = bus.in_payload[i*PAYLOAD_W +: PAYLOAD_W];
                selLast    = bus.in_last[i];
            end
        end
        inRange = int'(selDst) < N_OUT;
    end

    // Next-state for the lock FSM, round-robin pointer and output register.
    // A beat with an unroutable destination still moves the lock and the
    // pointer, but the register is left empty (or emptied by its drain).
    always_comb begin
        lockState_d  = lockState_q;
        lockIdx_d    = lockIdx_q;
        rrPtr_d      = rrPtr_q;
        chosen_d     = chosen_q;
        regValid_d   = regValid_q & ~drain;
        regSrc_d     = regSrc_q;
        regDst_d     = regDst_q;
        regPayload_d = regPayload_q;
        regLast_d    = regLast_q;
        if (accept) begin
            rrPtr_d     = grant;
            lockIdx_d   = grant;
            lockState_d = selLast ? LOCK_OPEN : LOCK_HELD;
            if (inRange) begin
                regValid_d   = 1'b1;
                regSrc_d     = selSrc;
                regDst_d     = selDst;
                regPayload_d = selPayload;
                regLast_d    = selLast;
                chosen_d     = grant;
            end
        end
    end

    // State registers. Reset puts input 0 first in line by parking the
    // pointer on the last input, and drops any held beat and open lock.
    always_ff @(posedge clk) begin
        if (!reset) begin
            lockState_q  <= LOCK_OPEN;
            lockIdx_q    <= '0;
            rrPtr_q      <= IDX_W'(N_IN - 1);
            chosen_q     <= '0;
            regValid_q   <= 1'b0;
            regSrc_q     <= '0;
            regDst_q     <= '0;
            regPayload_q <= '0;
            regLast_q    <= 1'b0;
        end else begin
            lockState_q  <= lockState_d;
            lockIdx_q    <= lockIdx_d;
            rrPtr_q      <= rrPtr_d;
            chosen_q     <= chosen_d;
            regValid_q   <= regValid_d;
            regSrc_q     <= regSrc_d;
            regDst_q     <= regDst_d;
            regPayload_q <= regPayload_d;
            regLast_q    <= regLast_d;
        end
    end

    // One-hot valid toward the addressed output; data fields are shared.
    always_comb begin
        bus.out_valid = '0;
        for (int j = 0; j < N_OUT; j++) begin
            bus.out_valid[j] = regValid_q & (int'(regDst_q) == j);
        end
    end

    assign bus.out_src     = regSrc_q;
    assign bus.out_dst     = regDst_q;
    assign bus.out_payload = regPayload_q;
    assign bus.out_last    = regLast_q;
    assign bus.chosen      = chosen_q;

`ifdef CORERISCV_BUS_DST_CHECK_EN
    logic             err_q, err_d;
    logic [SRC_W-1:0] errSrc_q, errSrc_d;

    // Sticky error: only the first unroutable beat records its source.
    always_comb begin
        err_d    = err_q;
        errSrc_d = errSrc_q;
        if (accept && !inRange && !err_q) begin
            err_d    = 1'b1;
            errSrc_d = selSrc;
        end
    end

    // Error capture registers, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            err_q    <= 1'b0;
            errSrc_q <= '0;
        end else begin
            err_q    <= err_d;
            errSrc_q <= errSrc_d;
        end
    end

    assign bus.err     = err_q;
    assign bus.err_src = errSrc_q;
`else
    assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_routed_lock_bus.sv
// ---------------------------------------------------------------------------
// tb_routed_lock_bus
//
// Purpose: self-checking bench for routed_lock_bus with N_IN=5, N_OUT=3 so
// that destination 3 is unroutable. Each input owns a queue of message
// beats. A reference model predicts grants and ready, and every beat it
// expects to be presented is pushed into a scoreboard; a separate monitor
// pops and compares whenever the bus presents a beat.
// Works with or without CORERISCV_BUS_DST_CHECK_EN.
// ---------------------------------------------------------------------------
module tb_routed_lock_bus;

    localparam int N_IN      = 5;
    localparam int N_OUT     = 3;
    localparam int SRC_W     = 2;
    localparam int DST_W     = 2;
    localparam int PAYLOAD_W = 4;
    localparam int IDX_W     = 3;

    typedef struct packed {
        logic [SRC_W-1:0]     src;
        logic [DST_W-1:0]     dst;
        logic [PAYLOAD_W-1:0] payload;
        logic                 last;
    } beat_t;

    typedef struct packed {
        beat_t            beat;
        logic [IDX_W-1:0] idx;
    } exp_t;

    typedef beat_t beatQ_t[$];

    logic clk;
    logic reset;

    routed_lock_bus_if #(
        .N_IN(N_IN), .N_OUT(N_OUT), .SRC_W(SRC_W), .DST_W(DST_W),
        .PAYLOAD_W(PAYLOAD_W), .IDX_W(IDX_W)
    ) bus ();

    routed_lock_bus #(
        .N_IN(N_IN), .N_OUT(N_OUT), .SRC_W(SRC_W), .DST_W(DST_W),
        .PAYLOAD_W(PAYLOAD_W), .IDX_W(IDX_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    beatQ_t inQ [N_IN];
    exp_t   sb[$];

    int vecCount  = 0;
    int missCount = 0;

    bit               mHeld;
    int               mHeldDst;
    bit               mLock;
    int               mLockIdx;
    int               mPtr;
    bit               mErr;
    logic [SRC_W-1:0] mErrSrc;

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so a wedged run still terminates.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, sb depth %0d", sb.size());
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic compare(input string name, input logic [63:0] act, input logic [63:0] req);
        vecCount++;
        if (act !== req) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic modelReset();
        mHeld    = 1'b0;
        mHeldDst = 0;
        mLock    = 1'b0;
        mLockIdx = 0;
        mPtr     = N_IN - 1;
        mErr     = 1'b0;
        mErrSrc  = '0;
    endtask

    // Queue one message of the given length on input i.
    task automatic pushMsg(input int i, input int beats, input int dst, input int src);
        beat_t b;
        for (int k = 0; k < beats; k++) begin
            b.src     = SRC_W'(src);
            b.dst     = DST_W'(dst);
            b.payload = PAYLOAD_W'($urandom);
            b.last    = (k == beats - 1);
            inQ[i].push_back(b);
        end
    endtask

    // Holds reset low for one clock edge; the held beat and any lock are
    // discarded, so the scoreboard and model start over.
    task automatic doReset();
        @(negedge clk);
        reset         = 1'b0;
        bus.in_valid  = '0;
        bus.out_ready = '0;
        sb.delete();
        modelReset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    // One clock of stimulus: drive queue heads on inputs enabled by vMask,
    // check ready/valid/err against the model, then advance the model by the
    // coming clock edge and push any beat that should be presented.
    task automatic applyStimulus(input logic [N_IN-1:0] vMask, input logic [N_OUT-1:0] rMask);
        logic [N_IN-1:0]  curValid;
        logic [N_IN-1:0]  expReady;
        logic [N_OUT-1:0] expOutValid;
        bit               pipeReady;
        bit               gValid;
        int               g;
        int               idx;
        beat_t            b;
        exp_t             e;

        @(negedge clk);
        for (int i = 0; i < N_IN; i++) begin
            curValid[i] = vMask[i] && (inQ[i].size() > 0);
            if (curValid[i]) begin
                b = inQ[i][0];
            end else begin
                b = beat_t'($urandom);
            end
            bus.in_valid[i]                        = curValid[i];
            bus.in_src[i*SRC_W +: SRC_W]           = b.src;
            bus.in_dst[i*DST_W +: DST_W]           = b.dst;
            bus.in_payload[i*PAYLOAD_W +: PAYLOAD_W] = b.payload;
            bus.in_last[i]                         = b.last;
        end
        bus.out_ready = rMask;
        #1;

        pipeReady = !mHeld || rMask[mHeldDst];
        gValid    = 1'b0;
        g         = 0;
        if (mLock) begin
            g      = mLockIdx;
            gValid = curValid[g];
        end else begin
            for (int k = 1; k <= N_IN; k++) begin
                idx = (mPtr + k) % N_IN;
                if (!gValid && curValid[idx]) begin
                    g      = idx;
                    gValid = 1'b1;
                end
            end
        end

        expReady = '0;
        if (pipeReady && gValid) expReady[g] = 1'b1;
        expOutValid = '0;
        if (mHeld) expOutValid[mHeldDst] = 1'b1;

        compare("in_ready", 64'(bus.in_ready), 64'(expReady));
        compare("out_valid", 64'(bus.out_valid), 64'(expOutValid));
`ifdef CORERISCV_BUS_DST_CHECK_EN
        compare("err", 64'(bus.err), 64'(mErr));
        if (mErr) compare("err_src", 64'(bus.err_src), 64'(mErrSrc));
`else
        compare("err", 64'(bus.err), 64'(0));
`endif

        if (mHeld && rMask[mHeldDst]) mHeld = 1'b0;
        if (pipeReady && gValid) begin
            b        = inQ[g].pop_front();
            mPtr     = g;
            mLock    = !b.last;
            mLockIdx = g;
            if (int'(b.dst) < N_OUT) begin
                e.beat = b;
                e.idx  = IDX_W'(g);
                sb.push_back(e);
                mHeld    = 1'b1;
                mHeldDst = int'(b.dst);
            end else if (!mErr) begin
                mErr    = 1'b1;
                mErrSrc = b.src;
            end
        end
    endtask

    // Compares the presented beat with the scoreboard head and retires it
    // when the addressed output accepts it.
    task automatic checkOutput();
        exp_t             e;
        logic [N_OUT-1:0] ov;
        if (sb.size() == 0) begin
            compare("spurious out_valid", 64'(bus.out_valid), 64'(0));
        end else begin
            e  = sb[0];
            ov = '0;
            ov[e.beat.dst] = 1'b1;
            compare("out beat",
                    64'({bus.out_valid, bus.out_src, bus.out_dst, bus.out_payload, bus.out_last, bus.chosen}),
                    64'({ov, e.beat, e.idx}));
            if (bus.out_ready[e.beat.dst]) void'(sb.pop_front());
        end
    endtask

    // Monitor: runs after the stimulus has settled each cycle and only looks
    // at the bus when a beat is being presented.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (reset && (bus.out_valid != '0)) checkOutput();
        end
    end

    // Main sequence: directed scenarios, then randomized traffic, then drain.
    initial begin
        int budget;
        reset          = 1'b0;
        bus.in_valid   = '0;
        bus.in_src     = '0;
        bus.in_dst     = '0;
        bus.in_payload = '0;
        bus.in_last    = '0;
        bus.out_ready  = '0;
        modelReset();
        repeat (3) @(negedge clk);
        reset = 1'b1;

        $display("[TB] single-beat rotation");
        for (int i = 0; i < N_IN; i++) pushMsg(i, 1, i % N_OUT, i % 4);
        repeat (7) applyStimulus('1, '1);

        $display("[TB] locked 3-beat message from input 2");
        pushMsg(2, 3, 1, 2);
        pushMsg(0, 1, 0, 0);
        pushMsg(3, 1, 2, 3);
        applyStimulus(5'b00100, '1);
        repeat (6) applyStimulus(5'b01101, '1);

        $display("[TB] output stall on destination 2");
        pushMsg(4, 1, 2, 1);
        pushMsg(0, 1, 0, 0);
        pushMsg(1, 1, 1, 1);
        applyStimulus(5'b10000, '1);
        repeat (5) applyStimulus('1, 3'b011);
        repeat (4) applyStimulus('1, '1);

        $display("[TB] out-of-range destination");
        pushMsg(1, 1, 3, 2);
        pushMsg(1, 1, 3, 1);
        repeat (2) applyStimulus(5'b00010, '1);
        repeat (2) applyStimulus('0, '1);

        $display("[TB] reset while locked");
        pushMsg(3, 3, 0, 3);
        applyStimulus(5'b01000, '1);
        pushMsg(0, 1, 2, 0);
        doReset();
        repeat (6) applyStimulus(5'b01001, '1);

        $display("[TB] randomized traffic");
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < N_IN; i++) begin
                if (inQ[i].size() < 2) begin
                    pushMsg(i, $urandom_range(1, 3),
                            ($urandom_range(0, 7) == 0) ? 3 : $urandom_range(0, N_OUT - 1),
                            $urandom_range(0, 3));
                end
            end
            applyStimulus(N_IN'($urandom | $urandom),
                          N_OUT'($urandom | $urandom));
        end

        budget = 0;
        while (sb.size() > 0 && budget < 50) begin
            applyStimulus('0, '1);
            budget++;
        end
        #5;
        compare("scoreboard drained", 64'(sb.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
